// File: rtl/bp_pkg.sv
// Shared branch-prediction types: kind encoding, pdch field offsets, and the
// per-prediction metadata bundle queued between fetch and EX.
package bp_pkg;

    localparam int unsigned BP_ADDR_WIDTH = 30;
    localparam int unsigned BP_H_WIDTH    = 14;

    typedef enum logic [2:0] {
        NOT_JUMP      = 3'd0,
        DIRECT_JUMP   = 3'd1,
        JUMP          = 3'd2,
        CALL          = 3'd3,
        RET           = 3'd4,
        INDIRECT_JUMP = 3'd5,
        OTHER_JUMP    = 3'd6
    } bp_kind_e;

    // pdch = {taken_g[1:0], taken_b[1:0], ch_btb_ras[1:0], ch_b_g[1:0]}
    localparam int unsigned PDCH_TAKEN_G_HI = 7;
    localparam int unsigned PDCH_TAKEN_B_HI = 5;
    localparam int unsigned PDCH_CH_BR_LO   = 2;
    localparam int unsigned PDCH_CH_BG_LO   = 0;

    localparam logic [2:0] STAT_UPDATES   = 3'd0;
    localparam logic [2:0] STAT_MIS_TAKEN = 3'd1;
    localparam logic [2:0] STAT_MIS_KIND  = 3'd2;
    localparam logic [2:0] STAT_MIS_NPC   = 3'd3;
    localparam logic [2:0] STAT_REDIRECTS = 3'd4;

    typedef struct packed {
        logic [BP_ADDR_WIDTH-1:0] pc;
        logic [BP_ADDR_WIDTH-1:0] npc;
        logic [2:0]               kind;
        logic                     taken;
        logic [BP_H_WIDTH-1:0]    bh;
        logic [1:0]               choice;
        logic [7:0]               pdch;
    } pred_meta_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        return (en && (cnt != '1)) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/bp_meta_fifo.sv
// In-order prediction metadata FIFO; pointers carry one extra wrap bit.
// clear empties the queue and takes priority over a same-cycle push/pop.
module bp_meta_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/branch_resolver.sv
// EX-side branch resolution: pops queued predictions, compares with the real
// outcome, registers the predictor update and front-end redirect.
// Optional BR_STAT_EN adds saturating event counters on stat_sel/stat_data.
// The queued bundle uses bp_pkg widths; ADDR_WIDTH/h_width must match them.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int unsigned h_width    = BP_H_WIDTH,
    parameter int unsigned ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int unsigned META_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pdc_valid,
    output logic                  pdc_ready,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    input  logic [ADDR_WIDTH-1:0] npc_pdc,
    input  logic [2:0]            kind_pdc,
    input  logic                  taken_pdc,
    input  logic [h_width-1:0]    bh_pdc,
    input  logic [1:0]            choice_pdc,
    input  logic [7:0]            pdch,
    input  logic                  ex_valid,
    input  logic [2:0]            kind_real,
    input  logic                  taken_real,
    input  logic [ADDR_WIDTH-1:0] npc_real,
    input  logic [ADDR_WIDTH-1:0] ret_pc_real,
    output logic                  update_en,
    output logic [ADDR_WIDTH-1:0] pc_ex,
    output logic [ADDR_WIDTH-1:0] npc_ex,
    output logic [ADDR_WIDTH-1:0] ret_pc_ex,
    output logic [2:0]            kind_ex,
    output logic                  taken_real_o,
    output logic [h_width-1:0]    bh_ex,
    output logic [2:0]            mis_pdc,
    output logic [1:0]            choice_real,
    output logic [1:0]            choice_pdc_ex,
    output logic [7:0]            out_pdch,
    output logic                  redirect,
    output logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef BR_STAT_EN
    ,
    input  logic [2:0]            stat_sel,
    output logic [31:0]           stat_data
`endif
);
    localparam int unsigned META_W = $bits(pred_meta_t);

    pred_meta_t  push_meta;
    pred_meta_t  head;
    logic [META_W-1:0] head_raw;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        mis_kind;
    logic        mis_taken;
    logic        mis_npc;
    logic [1:0]  choice_nxt;
    logic        tg_hi;
    logic        tb_hi;

    assign pdc_ready = !fifo_full || ex_valid;
    assign push      = pdc_valid && pdc_ready;
    // Entries still queued during the redirect cycle are wrong-path; never pop them.
    assign pop       = ex_valid && !fifo_empty && !redirect;

    always_comb begin
        push_meta        = '0;
        push_meta.pc     = pc_if;
        push_meta.npc    = npc_pdc;
        push_meta.kind   = kind_pdc;
        push_meta.taken  = taken_pdc;
        push_meta.bh     = bh_pdc;
        push_meta.choice = choice_pdc;
        push_meta.pdch   = pdch;
    end

    bp_meta_fifo #(
        .DEPTH  (META_DEPTH),
        .DATA_W (META_W)
    ) u_meta_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push),
        .wdata (push_meta),
        .pop   (pop),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = pred_meta_t'(head_raw);

    always_comb begin
        mis_kind  = (kind_real != head.kind);
        mis_taken = (taken_real != head.taken);
        mis_npc   = taken_real && (npc_real != head.npc);
        tg_hi     = head.pdch[PDCH_TAKEN_G_HI];
        tb_hi     = head.pdch[PDCH_TAKEN_B_HI];
        choice_nxt = head.choice;
        if (tg_hi == taken_real && tb_hi != taken_real) begin
            choice_nxt[0] = 1'b1;
        end else if (tb_hi == taken_real && tg_hi != taken_real) begin
            choice_nxt[0] = 1'b0;
        end
        if (kind_real == RET) begin
            choice_nxt[1] = head.choice[1] ^ mis_npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update_en     <= 1'b0;
            redirect      <= 1'b0;
            pc_ex         <= '0;
            npc_ex        <= '0;
            ret_pc_ex     <= '0;
            kind_ex       <= '0;
            taken_real_o  <= 1'b0;
            bh_ex         <= '0;
            mis_pdc       <= '0;
            choice_real   <= '0;
            choice_pdc_ex <= '0;
            out_pdch      <= '0;
            redirect_pc   <= '0;
        end else begin
            update_en <= pop;
            redirect  <= pop && (mis_kind || mis_taken || mis_npc);
            if (pop) begin
                pc_ex         <= head.pc;
                npc_ex        <= npc_real;
                ret_pc_ex     <= ret_pc_real;
                kind_ex       <= kind_real;
                taken_real_o  <= taken_real;
                bh_ex         <= head.bh;
                mis_pdc       <= {mis_npc, mis_kind, mis_taken};
                choice_real   <= choice_nxt;
                choice_pdc_ex <= head.choice;
                out_pdch      <= head.pdch;
                redirect_pc   <= taken_real ? npc_real : head.pc + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef BR_STAT_EN
    logic [31:0] stat_cnt [5];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 5; i++) stat_cnt[i] <= '0;
        end else begin
            stat_cnt[0] <= sat_inc(stat_cnt[0], pop);
            stat_cnt[1] <= sat_inc(stat_cnt[1], pop && mis_taken);
            stat_cnt[2] <= sat_inc(stat_cnt[2], pop && mis_kind);
            stat_cnt[3] <= sat_inc(stat_cnt[3], pop && mis_npc);
            stat_cnt[4] <= sat_inc(stat_cnt[4], pop && (mis_kind || mis_taken || mis_npc));
        end
    end

    always_comb begin
        stat_data = '0;
        case (stat_sel)
            STAT_UPDATES:   stat_data = stat_cnt[0];
            STAT_MIS_TAKEN: stat_data = stat_cnt[1];
            STAT_MIS_KIND:  stat_data = stat_cnt[2];
            STAT_MIS_NPC:   stat_data = stat_cnt[3];
            STAT_REDIRECTS: stat_data = stat_cnt[4];
            default:        stat_data = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver (default build, BR_STAT_EN undefined).
// A queue-based reference model predicts each registered update and redirect.
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        rst;
    logic        pdc_valid;
    logic        pdc_ready;
    logic [29:0] pc_if, npc_pdc, npc_real, ret_pc_real;
    logic [2:0]  kind_pdc, kind_real;
    logic        taken_pdc, taken_real, ex_valid;
    logic [13:0] bh_pdc;
    logic [1:0]  choice_pdc;
    logic [7:0]  pdch;
    logic        update_en, taken_real_o, redirect;
    logic [29:0] pc_ex, npc_ex, ret_pc_ex, redirect_pc;
    logic [2:0]  kind_ex, mis_pdc;
    logic [13:0] bh_ex;
    logic [1:0]  choice_real, choice_pdc_ex;
    logic [7:0]  out_pdch;

    branch_resolver #(.h_width(14), .ADDR_WIDTH(30), .META_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .pdc_valid(pdc_valid), .pdc_ready(pdc_ready),
        .pc_if(pc_if), .npc_pdc(npc_pdc), .kind_pdc(kind_pdc), .taken_pdc(taken_pdc),
        .bh_pdc(bh_pdc), .choice_pdc(choice_pdc), .pdch(pdch), .ex_valid(ex_valid),
        .kind_real(kind_real), .taken_real(taken_real), .npc_real(npc_real),
        .ret_pc_real(ret_pc_real), .update_en(update_en), .pc_ex(pc_ex), .npc_ex(npc_ex),
        .ret_pc_ex(ret_pc_ex), .kind_ex(kind_ex), .taken_real_o(taken_real_o),
        .bh_ex(bh_ex), .mis_pdc(mis_pdc), .choice_real(choice_real),
        .choice_pdc_ex(choice_pdc_ex), .out_pdch(out_pdch), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] pc, npc;
        logic [2:0]  kind;
        logic        taken;
        logic [13:0] bh;
        logic [1:0]  choice;
        logic [7:0]  pdch;
    } ent_t;

    ent_t mq[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Expected registered outputs (hold between updates, like the real bus)
    logic        exp_upd, exp_redir, exp_ready, obs_ready, exp_tr;
    logic [29:0] exp_pc, exp_npc, exp_ret, exp_rpc;
    logic [2:0]  exp_kind, exp_mis;
    logic [13:0] exp_bh;
    logic [1:0]  exp_cr, exp_cp;
    logic [7:0]  exp_pdch;

    function automatic ent_t mk(input logic [29:0] pc, input logic [29:0] npc,
                                input logic [2:0] kind, input logic taken,
                                input logic [1:0] ch, input logic [7:0] pd);
        ent_t e;
        e.pc = pc; e.npc = npc; e.kind = kind; e.taken = taken;
        e.bh = 14'(pc * 3); e.choice = ch; e.pdch = pd;
        return e;
    endfunction

    task automatic clear_exp();
        exp_upd = 0; exp_redir = 0; exp_tr = 0; exp_pc = 0; exp_npc = 0; exp_ret = 0;
        exp_rpc = 0; exp_kind = 0; exp_mis = 0; exp_bh = 0; exp_cr = 0; exp_cp = 0;
        exp_pdch = 0;
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic clk_cycle(input logic pv, input ent_t e, input logic ev,
                             input logic [2:0] kr, input logic tr,
                             input logic [29:0] nr, input logic [29:0] rr);
        ent_t h;
        logic flush, popped;
        pdc_valid = pv; pc_if = e.pc; npc_pdc = e.npc; kind_pdc = e.kind;
        taken_pdc = e.taken; bh_pdc = e.bh; choice_pdc = e.choice; pdch = e.pdch;
        ex_valid = ev; kind_real = kr; taken_real = tr; npc_real = nr; ret_pc_real = rr;
        #1;
        obs_ready = pdc_ready;
        exp_ready = (mq.size() < 8) || ev;
        flush = exp_redir;
        popped = 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (ev && mq.size() > 0) begin
                h = mq.pop_front();
                popped = 1;
            end
            if (pv && exp_ready) mq.push_back(e);
        end
        exp_upd = popped;
        exp_redir = 0;
        if (popped) begin
            exp_mis[0] = (tr != h.taken);
            exp_mis[1] = (kr != h.kind);
            exp_mis[2] = tr && (nr != h.npc);
            exp_redir = |exp_mis;
            if (h.pdch[7] == tr && h.pdch[5] != tr)      exp_cr[0] = 1'b1;
            else if (h.pdch[5] == tr && h.pdch[7] != tr) exp_cr[0] = 1'b0;
            else                                          exp_cr[0] = h.choice[0];
            exp_cr[1] = (kr == 3'd4) ? (h.choice[1] ^ exp_mis[2]) : h.choice[1];
            exp_pc = h.pc; exp_npc = nr; exp_ret = rr; exp_kind = kr; exp_tr = tr;
            exp_bh = h.bh; exp_cp = h.choice; exp_pdch = h.pdch;
            exp_rpc = tr ? nr : h.pc + 30'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ent_t z;
        z = mk(0, 0, 0, 0, 0, 0);
        clk_cycle(0, z, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        ent_t z;
        z = mk(0, 0, 0, 0, 0, 0);
        rst = 1;
        clk_cycle(0, z, 1, 0, 0, 0, 0);
        clk_cycle(1, z, 0, 0, 0, 0, 0);
        rst = 0;
        mq.delete();
        clear_exp();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (update_en !== 0 || redirect !== 0 || mis_pdc !== 0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: upd=%b redir=%b mis=%b required 0 0 000", update_en, redirect, mis_pdc);
        end
        tests_run++;
        if (pc_ex !== 0 || redirect_pc !== 0 || out_pdch !== 0 || choice_real !== 0 || bh_ex !== 0) begin
            tests_failed++;
            $display("FAIL reset_data: pc_ex=%h rpc=%h pdch=%h cr=%b bh=%h required all 0", pc_ex, redirect_pc, out_pdch, choice_real, bh_ex);
        end
        tests_run++;
        if (pdc_ready !== 1) begin
            tests_failed++;
            $display("FAIL reset_ready: pdc_ready=%b required 1", pdc_ready);
        end
    endtask

    task automatic test_match();
        do_reset();
        clk_cycle(1, mk(30'h100, 30'h120, 3'd1, 1, 2'b00, 8'h00), 0, 0, 0, 0, 0);
        idle();
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd1, 1, 30'h120, 30'h0);
        tests_run++;
        if (update_en !== 1 || mis_pdc !== 3'b000 || redirect !== 0 || pc_ex !== 30'h100) begin
            tests_failed++;
            $display("FAIL match: upd=%b mis=%b redir=%b pc_ex=%h required 1 000 0 100", update_en, mis_pdc, redirect, pc_ex);
        end
        idle();
        tests_run++;
        if (update_en !== 0 || pc_ex !== 30'h100 || npc_ex !== 30'h120) begin
            tests_failed++;
            $display("FAIL hold: upd=%b pc_ex=%h npc_ex=%h required 0 100 120", update_en, pc_ex, npc_ex);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        clk_cycle(1, mk(30'h100, 30'h120, 3'd1, 1, 2'b00, 8'h00), 0, 0, 0, 0, 0);
        clk_cycle(1, mk(30'h104, 30'h140, 3'd1, 1, 2'b00, 8'h00), 0, 0, 0, 0, 0);
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd1, 0, 30'h101, 30'h0);
        tests_run++;
        if (update_en !== 1 || mis_pdc !== 3'b001 || redirect !== 1 || redirect_pc !== 30'h101) begin
            tests_failed++;
            $display("FAIL mispredict: upd=%b mis=%b redir=%b rpc=%h required 1 001 1 101", update_en, mis_pdc, redirect, redirect_pc);
        end
        clk_cycle(1, mk(30'h200, 30'h201, 3'd0, 0, 2'b00, 8'h00), 0, 0, 0, 0, 0);
        tests_run++;
        if (update_en !== 0 || redirect !== 0) begin
            tests_failed++;
            $display("FAIL redirect_pulse: upd=%b redir=%b required 0 0", update_en, redirect);
        end
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd1, 1, 30'h140, 30'h0);
        tests_run++;
        if (update_en !== 0 || redirect !== 0) begin
            tests_failed++;
            $display("FAIL flush_empty: upd=%b redir=%b required 0 0 (queue cleared)", update_en, redirect);
        end
    endtask

    task automatic test_full_wrap();
        ent_t h;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clk_cycle(1, mk(30'h80 + 30'(i), 30'h90, 3'd0, 0, 0, 0), 0, 0, 0, 0, 0);
            h = mq[0];
            clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, h.kind, h.taken, h.npc, 0);
        end
        for (int i = 0; i < 8; i++)
            clk_cycle(1, mk(30'h200 + 30'(i), 30'h300, 3'd2, 1, 2'b01, 8'h0F), 0, 0, 0, 0, 0);
        idle();
        tests_run++;
        if (obs_ready !== 0) begin
            tests_failed++;
            $display("FAIL full_ready: pdc_ready=%b required 0", obs_ready);
        end
        h = mq[0];
        clk_cycle(1, mk(30'h208, 30'h300, 3'd2, 1, 2'b01, 8'h0F), 1, h.kind, h.taken, h.npc, 30'h55);
        tests_run++;
        if (obs_ready !== 1 || update_en !== 1 || pc_ex !== 30'h200 || ret_pc_ex !== 30'h55) begin
            tests_failed++;
            $display("FAIL push_pop_full: ready=%b upd=%b pc_ex=%h ret=%h required 1 1 200 55", obs_ready, update_en, pc_ex, ret_pc_ex);
        end
        idle();
        tests_run++;
        if (obs_ready !== 0) begin
            tests_failed++;
            $display("FAIL count_8: pdc_ready=%b required 0", obs_ready);
        end
        for (int i = 1; i <= 8; i++) begin
            h = mq[0];
            clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, h.kind, h.taken, h.npc, 0);
            tests_run++;
            if (update_en !== 1 || pc_ex !== 30'h200 + 30'(i) || redirect !== 0) begin
                tests_failed++;
                $display("FAIL drain_order[%0d]: upd=%b pc_ex=%h redir=%b required 1 %h 0", i, update_en, pc_ex, redirect, 30'h200 + 30'(i));
            end
        end
    endtask

    task automatic test_choice();
        do_reset();
        clk_cycle(1, mk(30'h40, 30'h50, 3'd1, 0, 2'b00, 8'b10_00_00_00), 0, 0, 0, 0, 0);
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd1, 1, 30'h50, 0);
        tests_run++;
        if (choice_real !== 2'b01 || mis_pdc !== 3'b001 || redirect_pc !== 30'h50) begin
            tests_failed++;
            $display("FAIL choice_g: cr=%b mis=%b rpc=%h required 01 001 050", choice_real, mis_pdc, redirect_pc);
        end
        idle();
    endtask

    task automatic test_ret();
        do_reset();
        clk_cycle(1, mk(30'h60, 30'h300, 3'd4, 1, 2'b10, 8'h00), 0, 0, 0, 0, 0);
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd4, 1, 30'h304, 0);
        tests_run++;
        if (mis_pdc !== 3'b100 || choice_real !== 2'b00 || redirect !== 1) begin
            tests_failed++;
            $display("FAIL ret_mis: mis=%b cr=%b redir=%b required 100 00 1", mis_pdc, choice_real, redirect);
        end
        idle();
        clk_cycle(1, mk(30'h60, 30'h300, 3'd4, 1, 2'b10, 8'h00), 0, 0, 0, 0, 0);
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd4, 1, 30'h300, 0);
        tests_run++;
        if (mis_pdc !== 3'b000 || choice_real !== 2'b10 || redirect !== 0 || kind_ex !== 3'd4) begin
            tests_failed++;
            $display("FAIL ret_ok: mis=%b cr=%b redir=%b kind=%0d required 000 10 0 4", mis_pdc, choice_real, redirect, kind_ex);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++)
            clk_cycle(1, mk(30'h400 + 30'(i), 30'h0, 3'd0, 0, 0, 0), 0, 0, 0, 0, 0);
        do_reset();
        tests_run++;
        if (pdc_ready !== 1 || update_en !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid: ready=%b upd=%b required 1 0", pdc_ready, update_en);
        end
        clk_cycle(0, mk(0, 0, 0, 0, 0, 0), 1, 3'd0, 0, 0, 0);
        tests_run++;
        if (update_en !== 0 || redirect !== 0) begin
            tests_failed++;
            $display("FAIL empty_pop: upd=%b redir=%b required 0 0", update_en, redirect);
        end
    endtask

    task automatic test_random();
        ent_t e, h;
        logic ev, tr;
        logic [2:0] kr;
        logic [29:0] nr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e = mk(30'($urandom), 30'($urandom_range(0, 3)), 3'($urandom_range(0, 6)),
                   1'($urandom), 2'($urandom), 8'($urandom));
            ev = ($urandom_range(0, 9) < 4);
            kr = 3'($urandom_range(0, 6)); tr = 1'($urandom); nr = 30'($urandom_range(0, 3));
            if (mq.size() > 0 && $urandom_range(0, 9) < 6) begin
                h = mq[0];
                kr = h.kind; tr = h.taken; nr = h.npc;
            end
            clk_cycle(1'($urandom_range(0, 9) < 5), e, ev, kr, tr, nr, 30'($urandom));
            tests_run++;
            if (obs_ready !== exp_ready || update_en !== exp_upd || redirect !== exp_redir) begin
                tests_failed++;
                $display("FAIL rand_ctrl[%0d]: ready=%b upd=%b redir=%b required %b %b %b", n, obs_ready, update_en, redirect, exp_ready, exp_upd, exp_redir);
            end
            tests_run++;
            if (pc_ex !== exp_pc || npc_ex !== exp_npc || ret_pc_ex !== exp_ret || kind_ex !== exp_kind ||
                taken_real_o !== exp_tr || bh_ex !== exp_bh || mis_pdc !== exp_mis || choice_real !== exp_cr ||
                choice_pdc_ex !== exp_cp || out_pdch !== exp_pdch || redirect_pc !== exp_rpc) begin
                tests_failed++;
                $display("FAIL rand_data[%0d]: pc=%h npc=%h mis=%b cr=%b rpc=%h required %h %h %b %b %h", n, pc_ex, npc_ex, mis_pdc, choice_real, redirect_pc, exp_pc, exp_npc, exp_mis, exp_cr, exp_rpc);
            end
        end
    endtask

    initial begin
        rst = 1; pdc_valid = 0; ex_valid = 0;
        clear_exp();
        test_reset();
        test_match();
        test_mispredict();
        test_full_wrap();
        test_choice();
        test_ret();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
